bcd_calculator: RTL and testbench

- Clocked, parametrised successor to the single-digit two-operand calculator.
- Two DIGITS-wide BCD operands are built by counting button presses, each press being a rising edge on the button input.
- On Equals, the block computes A+B or A−B over multiple cycles, one digit per cycle. The result is shown as sign-magnitude on seven-segment outputs.
- It sits between the board push-buttons and the seven-segment display drivers.

---
 rtl/bcd_calculator.sv | 229 ++++++++++++++++++++++
 tb/tb_bcd_calculator.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_calculator.sv
// Two-operand BCD add/subtract calculator: operands counted from button edges,
// result computed one digit per cycle and shown sign-magnitude on 7-segment outputs.
module bcd_calculator #(
   parameter int DIGITS = 2
) (
   input  logic                    Clock,
   input  logic                    Reset,
   input  logic                    Button1,
   input  logic                    Button2,
   input  logic                    Operation,
   input  logic                    Equals,
   output logic [7*DIGITS-1:0]     SegA,
   output logic [7*DIGITS-1:0]     SegB,
   output logic [7*(DIGITS+1)-1:0] SegR,
   output logic                    Minus,
   output logic                    Busy,
   output logic                    Done
);

   localparam int AW = 4 * DIGITS;
   localparam int RW = 4 * (DIGITS + 1);
   localparam logic [2:0] LAST_IDX = 3'(DIGITS - 1);

   typedef enum logic [1:0] {IDLE, CMP, CALC, SHOW} state_t;

   state_t          state_reg, state_next;
   logic [AW-1:0]   a_reg, a_next;
   logic [AW-1:0]   b_reg, b_next;
   logic [AW-1:0]   x_reg, x_next;
   logic [AW-1:0]   y_reg, y_next;
   logic [AW-1:0]   work_reg, work_next;
   logic [RW-1:0]   res_reg, res_next;
   logic [2:0]      idx_reg, idx_next;
   logic            carry_reg, carry_next;
   logic            op_reg, op_next;
   logic            neg_reg, neg_next;
   logic            minus_reg, minus_next;
   logic            valid_reg, valid_next;
   logic            done_reg, done_next;
   logic            b1_prev_reg, b2_prev_reg, eq_prev_reg;

   logic            b1_edge, b2_edge, eq_edge;
   logic [3:0]      xd, yd, digit;
   logic [4:0]      sum5, diff5;
   logic            cout;

   function automatic logic [AW-1:0] bcd_inc(input logic [AW-1:0] v);
      logic [AW-1:0] r;
      logic          c;
      r = v;
      c = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (c) begin
            if (r[4*i +: 4] == 4'd9) begin
               r[4*i +: 4] = 4'd0;
            end else begin
               r[4*i +: 4] = r[4*i +: 4] + 4'd1;
               c = 1'b0;
            end
         end
      end
      return r;
   endfunction

   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h3F;
         4'd1:    s = 7'h06;
         4'd2:    s = 7'h5B;
         4'd3:    s = 7'h4F;
         4'd4:    s = 7'h66;
         4'd5:    s = 7'h6D;
         4'd6:    s = 7'h7D;
         4'd7:    s = 7'h07;
         4'd8:    s = 7'h7F;
         4'd9:    s = 7'h6F;
         default: s = 7'h00;
      endcase
      return s;
   endfunction

   assign b1_edge = Button1 & ~b1_prev_reg;
   assign b2_edge = Button2 & ~b2_prev_reg;
   assign eq_edge = Equals  & ~eq_prev_reg;

   // Single-digit datapath: operands are walked least-significant digit first.
   always_comb begin
      xd    = x_reg[{idx_reg, 2'b00} +: 4];
      yd    = y_reg[{idx_reg, 2'b00} +: 4];
      sum5  = {1'b0, xd} + {1'b0, yd} + {4'b0000, carry_reg};
      diff5 = {1'b0, xd} - {1'b0, yd} - {4'b0000, carry_reg};
      digit = 4'd0;
      cout  = 1'b0;
      if (!op_reg) begin
         if (sum5 > 5'd9) begin
            digit = 4'(sum5 + 5'd6);
            cout  = 1'b1;
         end else begin
            digit = sum5[3:0];
         end
      end else begin
         if (diff5[4]) begin
            digit = 4'(diff5 + 5'd10);
            cout  = 1'b1;
         end else begin
            digit = diff5[3:0];
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      a_next     = a_reg;
      b_next     = b_reg;
      x_next     = x_reg;
      y_next     = y_reg;
      work_next  = work_reg;
      res_next   = res_reg;
      idx_next   = idx_reg;
      carry_next = carry_reg;
      op_next    = op_reg;
      neg_next   = neg_reg;
      minus_next = minus_reg;
      valid_next = valid_reg;
      done_next  = 1'b0;
      case (state_reg)
         IDLE, SHOW: begin
            if (b1_edge) a_next = bcd_inc(a_reg);
            if (b2_edge) b_next = bcd_inc(b_reg);
            if (eq_edge) begin
               op_next    = Operation;
               state_next = CMP;
            end
         end
         CMP: begin
            // Packed BCD compares correctly as plain binary.
            if (op_reg && (b_reg > a_reg)) begin
               x_next   = b_reg;
               y_next   = a_reg;
               neg_next = 1'b1;
            end else begin
               x_next   = a_reg;
               y_next   = b_reg;
               neg_next = 1'b0;
            end
            idx_next   = 3'd0;
            carry_next = 1'b0;
            work_next  = '0;
            state_next = CALC;
         end
         CALC: begin
            work_next[{idx_reg, 2'b00} +: 4] = digit;
            carry_next = cout;
            idx_next   = idx_reg + 3'd1;
            if (idx_reg == LAST_IDX) begin
               res_next   = {3'b000, cout & ~op_reg, work_next};
               minus_next = neg_reg;
               valid_next = 1'b1;
               done_next  = 1'b1;
               state_next = SHOW;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_reg   <= IDLE;
         a_reg       <= '0;
         b_reg       <= '0;
         x_reg       <= '0;
         y_reg       <= '0;
         work_reg    <= '0;
         res_reg     <= '0;
         idx_reg     <= 3'd0;
         carry_reg   <= 1'b0;
         op_reg      <= 1'b0;
         neg_reg     <= 1'b0;
         minus_reg   <= 1'b0;
         valid_reg   <= 1'b0;
         done_reg    <= 1'b0;
         b1_prev_reg <= 1'b0;
         b2_prev_reg <= 1'b0;
         eq_prev_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         a_reg       <= a_next;
         b_reg       <= b_next;
         x_reg       <= x_next;
         y_reg       <= y_next;
         work_reg    <= work_next;
         res_reg     <= res_next;
         idx_reg     <= idx_next;
         carry_reg   <= carry_next;
         op_reg      <= op_next;
         neg_reg     <= neg_next;
         minus_reg   <= minus_next;
         valid_reg   <= valid_next;
         done_reg    <= done_next;
         b1_prev_reg <= Button1;
         b2_prev_reg <= Button2;
         eq_prev_reg <= Equals;
      end
   end

   assign Busy  = (state_reg == CMP) || (state_reg == CALC);
   assign Done  = done_reg;
   assign Minus = minus_reg;

   genvar gi;
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_opnd
         assign SegA[7*gi +: 7] = seg7(a_reg[4*gi +: 4]);
         assign SegB[7*gi +: 7] = seg7(b_reg[4*gi +: 4]);
      end
      for (gi = 0; gi <= DIGITS; gi++) begin : g_res
         // Only the top result digit is leading-zero blanked.
         if (gi == DIGITS) begin : g_top
            assign SegR[7*gi +: 7] = (!valid_reg || res_reg[4*gi +: 4] == 4'd0)
                                     ? 7'b0000000 : seg7(res_reg[4*gi +: 4]);
         end else begin : g_low
            assign SegR[7*gi +: 7] = !valid_reg ? 7'b0000000 : seg7(res_reg[4*gi +: 4]);
         end
      end
   endgenerate

endmodule

// File: tb/tb_bcd_calculator.sv
// Directed bench for bcd_calculator (DIGITS=2): hand-computed operands and results.
module tb_bcd_calculator;

   logic        clk = 1'b0;
   logic        rst, b1, b2, op, eq;
   logic [13:0] sega, segb;
   logic [20:0] segr;
   logic        minus, busy, done;

   int n_checks = 0;
   int n_errors = 0;

   bcd_calculator #(.DIGITS(2)) dut (
      .Clock(clk), .Reset(rst), .Button1(b1), .Button2(b2),
      .Operation(op), .Equals(eq),
      .SegA(sega), .SegB(segb), .SegR(segr),
      .Minus(minus), .Busy(busy), .Done(done)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] seg7(input int d);
      logic [6:0] t [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                             7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
      return t[d];
   endfunction

   function automatic logic [13:0] exp_op(input int v);
      return {seg7((v / 10) % 10), seg7(v % 10)};
   endfunction

   function automatic logic [20:0] exp_res(input int v);
      logic [6:0] top;
      top = (v / 100 == 0) ? 7'h00 : seg7(v / 100);
      return {top, seg7((v / 10) % 10), seg7(v % 10)};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end else begin
         $display("ok   %s = %h", tag, got);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic set_ops(input int a, input int b);
      int n;
      do_reset();
      n = (a > b) ? a : b;
      for (int i = 0; i < n; i++) begin
         b1 = (i < a);
         b2 = (i < b);
         tick();
         b1 = 1'b0;
         b2 = 1'b0;
         tick();
      end
   endtask

   // Raises Equals for one edge, then waits (bounded) for Done.
   task automatic run_calc(input logic o, output int lat, output int busy_cnt);
      op = o;
      eq = 1'b1;
      tick();
      eq = 1'b0;
      lat = 1;
      busy_cnt = 0;
      while (!done && lat < 20) begin
         if (busy) busy_cnt++;
         tick();
         lat++;
      end
      check("done_seen", {31'b0, done}, 32'd1);
   endtask

   task automatic calc_case(input string tag, input int a, input int b, input logic o,
                            input int res, input logic neg);
      int lat, bc;
      set_ops(a, b);
      run_calc(o, lat, bc);
      check({tag, "_segr"}, {11'b0, segr}, {11'b0, exp_res(res)});
      check({tag, "_minus"}, {31'b0, minus}, {31'b0, neg});
      tick();
   endtask

   initial begin
      int lat, bc, dcnt;
      rst = 1'b1; b1 = 1'b0; b2 = 1'b0; op = 1'b0; eq = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      check("rst_sega", {18'b0, sega}, {18'b0, exp_op(0)});
      check("rst_segb", {18'b0, segb}, {18'b0, exp_op(0)});
      check("rst_segr", {11'b0, segr}, 32'd0);
      check("rst_minus", {31'b0, minus}, 32'd0);
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_done", {31'b0, done}, 32'd0);

      // 9 + 9 with latency and busy duration
      set_ops(9, 9);
      check("nine_sega", {18'b0, sega}, {18'b0, exp_op(9)});
      run_calc(1'b0, lat, bc);
      check("add99_segr", {11'b0, segr}, {11'b0, exp_res(18)});
      check("add99_minus", {31'b0, minus}, 32'd0);
      check("add99_lat", lat, 32'd4);
      check("add99_busy", bc, 32'd3);
      tick();
      check("done_width", {31'b0, done}, 32'd0);

      // 100 presses wraps A back to 00
      set_ops(100, 0);
      check("wrap_sega", {18'b0, sega}, {18'b0, exp_op(0)});

      calc_case("sub66", 6, 6, 1'b1, 0, 1'b0);
      calc_case("sub09", 0, 9, 1'b1, 9, 1'b1);
      calc_case("add4785", 47, 85, 1'b0, 132, 1'b0);
      calc_case("sub4785", 47, 85, 1'b1, 38, 1'b1);
      calc_case("sub5001", 50, 1, 1'b1, 49, 1'b0);
      calc_case("addmax", 99, 99, 1'b0, 198, 1'b0);

      // Equals held high for 10 cycles
      set_ops(2, 3);
      op = 1'b0;
      eq = 1'b1;
      dcnt = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (done) dcnt++;
      end
      eq = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (done) dcnt++;
      end
      check("eqhold_dones", dcnt, 32'd1);
      check("eqhold_segr", {11'b0, segr}, {11'b0, exp_res(5)});

      // Button1 edges while busy are discarded
      set_ops(3, 2);
      op = 1'b0;
      eq = 1'b1;
      tick();
      eq = 1'b0; b1 = 1'b1;
      tick();
      b1 = 1'b0;
      tick();
      b1 = 1'b1;
      tick();
      b1 = 1'b0;
      tick();
      tick();
      check("busyb1_sega", {18'b0, sega}, {18'b0, exp_op(3)});
      check("busyb1_segr", {11'b0, segr}, {11'b0, exp_res(5)});

      // Equals together with a Button2 edge uses B+1
      set_ops(3, 2);
      b2 = 1'b1;
      run_calc(1'b0, lat, bc);
      b2 = 1'b0;
      check("eqb2_segb", {18'b0, segb}, {18'b0, exp_op(3)});
      check("eqb2_segr", {11'b0, segr}, {11'b0, exp_res(6)});
      tick();

      // Operation toggled after the Equals edge has no effect
      set_ops(7, 2);
      op = 1'b1;
      eq = 1'b1;
      tick();
      eq = 1'b0;
      dcnt = 0;
      for (int i = 0; i < 6; i++) begin
         op = ~op;
         tick();
         if (done) dcnt++;
      end
      check("optog_dones", dcnt, 32'd1);
      check("optog_segr", {11'b0, segr}, {11'b0, exp_res(5)});
      check("optog_minus", {31'b0, minus}, 32'd0);

      // Reset at the second CALC cycle aborts without Done
      set_ops(5, 4);
      op = 1'b0;
      eq = 1'b1;
      tick();
      eq = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_sega", {18'b0, sega}, {18'b0, exp_op(0)});
      check("abort_segb", {18'b0, segb}, {18'b0, exp_op(0)});
      check("abort_segr", {11'b0, segr}, 32'd0);
      check("abort_busy", {31'b0, busy}, 32'd0);
      dcnt = 0;
      for (int i = 0; i < 6; i++) begin
         if (done) dcnt++;
         tick();
      end
      check("abort_dones", dcnt, 32'd0);
      run_calc(1'b0, lat, bc);
      check("zero_segr", {11'b0, segr}, {11'b0, exp_res(0)});
      check("zero_minus", {31'b0, minus}, 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
